// File: rtl/mem_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_arbiter
// Brief    : Two-requester arbiter and MAR/MDR bus sequencer for the memory/device block.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_arbiter #(
   parameter int RR_EN   = 1,
   parameter int TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   input  logic        req0_we,
   input  logic [15:0] req0_addr,
   input  logic [15:0] req0_wdata,
   output logic        req0_ack,
   input  logic        req1_valid,
   input  logic        req1_we,
   input  logic [15:0] req1_addr,
   input  logic [15:0] req1_wdata,
   output logic        req1_ack,
   output logic [15:0] rdata,
   output logic        err,
   output logic        busy,
   output logic [15:0] bus_drv,
   output logic        bus_drv_en,
   output logic        ld_mar,
   output logic        ld_mdr,
   output logic        mio_en,
   output logic        r_w,
   output logic        gate_mdr_en,
   input  logic [15:0] mdr_in,
   input  logic        dev_ready
);

   localparam logic [7:0] c_TIMEOUT = 8'(TIMEOUT);
   localparam logic       c_RR      = (RR_EN != 0);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_MAR   = 3'd1,
      S_WDATA = 3'd2,
      S_WRITE = 3'd3,
      S_READ  = 3'd4,
      S_RGATE = 3'd5,
      S_WAIT  = 3'd6,
      S_DONE  = 3'd7
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic        r_id;
   logic        r_we;
   logic [15:0] r_addr;
   logic [15:0] r_wdata;
   logic        r_last;
   logic [7:0]  r_cnt;
   logic        r_err;
   logic [15:0] r_rdata;

   logic        w_req_any;
   logic        w_gid;
   logic        w_timeout;

   assign w_req_any = req0_valid | req1_valid;
   // On contention the round-robin pointer favours whoever was not served last.
   assign w_gid     = (req0_valid & req1_valid) ? (c_RR & ~r_last) : (req1_valid & ~req0_valid);
   assign w_timeout = (r_cnt == c_TIMEOUT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_id    <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= 16'h0000;
         r_wdata <= 16'h0000;
         r_last  <= 1'b1;
         r_cnt   <= 8'd1;
         r_err   <= 1'b0;
         r_rdata <= 16'h0000;
      end else begin
         r_state <= w_next;
         r_cnt   <= (r_state == S_WAIT) ? r_cnt + 8'd1 : 8'd1;
         if (r_state == S_IDLE && w_req_any) begin
            r_id    <= w_gid;
            r_we    <= w_gid ? req1_we    : req0_we;
            r_addr  <= w_gid ? req1_addr  : req0_addr;
            r_wdata <= w_gid ? req1_wdata : req0_wdata;
         end
         if (r_state == S_RGATE) begin
            r_rdata <= mdr_in;
         end
         if (r_state == S_WAIT) begin
            if (dev_ready) begin
               r_err <= 1'b0;
            end else if (w_timeout) begin
               r_err <= 1'b1;
            end
         end
         if (r_state == S_DONE) begin
            r_last <= r_id;
         end
      end
   end

   always_comb begin
      w_next      = r_state;
      bus_drv     = 16'h0000;
      bus_drv_en  = 1'b0;
      ld_mar      = 1'b0;
      ld_mdr      = 1'b0;
      mio_en      = 1'b0;
      r_w         = 1'b0;
      gate_mdr_en = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_req_any) w_next = S_MAR;
         end
         S_MAR: begin
            bus_drv    = r_addr;
            bus_drv_en = 1'b1;
            ld_mar     = 1'b1;
            w_next     = r_we ? S_WDATA : S_READ;
         end
         S_WDATA: begin
            bus_drv    = r_wdata;
            bus_drv_en = 1'b1;
            ld_mdr     = 1'b1;
            w_next     = S_WRITE;
         end
         S_WRITE: begin
            mio_en = 1'b1;
            r_w    = 1'b1;
            w_next = S_WAIT;
         end
         S_READ: begin
            mio_en = 1'b1;
            ld_mdr = 1'b1;
            w_next = S_RGATE;
         end
         S_RGATE: begin
            gate_mdr_en = 1'b1;
            w_next      = S_WAIT;
         end
         S_WAIT: begin
            if (dev_ready || w_timeout) w_next = S_DONE;
         end
         S_DONE: begin
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign req0_ack = (r_state == S_DONE) & ~r_id;
   assign req1_ack = (r_state == S_DONE) &  r_id;
   assign err      = (r_state == S_DONE) & r_err;
   assign busy     = (r_state != S_IDLE);
   assign rdata    = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_arbiter
// Brief    : Directed bench with a MAR/MDR memory model and a fixed-priority twin.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req0_valid = 1'b0, req0_we = 1'b0;
   logic [15:0] req0_addr = 16'h0, req0_wdata = 16'h0;
   logic        req1_valid = 1'b0, req1_we = 1'b0;
   logic [15:0] req1_addr = 16'h0, req1_wdata = 16'h0;
   logic        req0_ack, req1_ack, err, busy;
   logic [15:0] rdata, bus_drv;
   logic        bus_drv_en, ld_mar, ld_mdr, mio_en, r_w, gate_mdr_en;
   logic [15:0] mdr_in;
   logic        dev_ready = 1'b1;

   logic        fp_v0 = 1'b0, fp_v1 = 1'b0;
   logic        fp_ack0, fp_ack1, fp_err, fp_busy;
   logic [15:0] fp_rdata, fp_bus_drv;
   logic        fp_bus_drv_en, fp_ld_mar, fp_ld_mdr, fp_mio_en, fp_r_w, fp_gate;
   logic        fp_ready = 1'b1;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mem_access_arbiter #(.RR_EN(1), .TIMEOUT(15)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
      .req0_wdata(req0_wdata), .req0_ack(req0_ack),
      .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
      .req1_wdata(req1_wdata), .req1_ack(req1_ack),
      .rdata(rdata), .err(err), .busy(busy), .bus_drv(bus_drv), .bus_drv_en(bus_drv_en),
      .ld_mar(ld_mar), .ld_mdr(ld_mdr), .mio_en(mio_en), .r_w(r_w),
      .gate_mdr_en(gate_mdr_en), .mdr_in(mdr_in), .dev_ready(dev_ready)
   );

   mem_access_arbiter #(.RR_EN(0), .TIMEOUT(15)) dut_fp (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(fp_v0), .req0_we(req0_we), .req0_addr(req0_addr),
      .req0_wdata(req0_wdata), .req0_ack(fp_ack0),
      .req1_valid(fp_v1), .req1_we(req1_we), .req1_addr(req1_addr),
      .req1_wdata(req1_wdata), .req1_ack(fp_ack1),
      .rdata(fp_rdata), .err(fp_err), .busy(fp_busy), .bus_drv(fp_bus_drv),
      .bus_drv_en(fp_bus_drv_en), .ld_mar(fp_ld_mar), .ld_mdr(fp_ld_mdr), .mio_en(fp_mio_en),
      .r_w(fp_r_w), .gate_mdr_en(fp_gate), .mdr_in(16'h0000), .dev_ready(fp_ready)
   );

   // Memory/device model: MAR, MDR, 256-word memory and a DDR register at FE06.
   logic [15:0] mar = 16'h0, mdr = 16'h0, ddr = 16'h0;
   logic [15:0] mem [256];
   logic        force_ready = 1'b1;
   logic [15:0] bus;

   assign bus    = bus_drv_en ? bus_drv : 16'h0000;
   assign mdr_in = mdr;

   always @(posedge clk) begin
      if (ld_mar) mar <= bus;
      if (ld_mdr) mdr <= mio_en ? ((mar == 16'hFE06) ? ddr : mem[mar[7:0]]) : bus;
      if (mio_en && r_w) begin
         if (mar == 16'hFE06) ddr <= mdr;
         else                 mem[mar[7:0]] <= mdr;
      end
      dev_ready <= force_ready && !(ld_mdr || mio_en);
      fp_ready  <= !(fp_ld_mdr || fp_mio_en);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic ack_of(input int id);
      return (id == 0) ? req0_ack : req1_ack;
   endfunction

   task automatic set_req(input int id, input logic v, input logic we,
                          input logic [15:0] a, input logic [15:0] d);
      if (id == 0) begin
         req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
      end else begin
         req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
      end
   endtask

   task automatic access(input int id, input logic we, input logic [15:0] a,
                         input logic [15:0] d, input int exp_lat, input logic exp_err);
      int   k;
      logic seen;
      @(posedge clk); #1;
      set_req(id, 1'b1, we, a, d);
      seen = 1'b0;
      k    = 0;
      while (!seen && k < 40) begin
         @(negedge clk);
         if (k == 1) chk("mar_phase", {ld_mar, ld_mdr, bus_drv_en, bus_drv}, {3'b101, a});
         if (k == 2) begin
            if (we) chk("wdata_phase", {ld_mdr, mio_en, bus_drv_en, bus_drv}, {3'b101, d});
            else    chk("read_phase", {ld_mdr, mio_en, r_w, bus_drv_en}, 4'b1100);
         end
         chk("strobe_excl", (ld_mar & ld_mdr) | (bus_drv_en & gate_mdr_en), 1'b0);
         if (ack_of(id)) begin
            seen = 1'b1;
            chk("latency", k, exp_lat);
            chk("err", err, exp_err);
         end else begin
            k++;
         end
      end
      set_req(id, 1'b0, we, a, d);
      chk("ack_seen", seen, 1'b1);
      @(negedge clk);
      chk("ack_pulse", {ack_of(id), busy}, 2'b00);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int order [4];
      int n, cyc, fp0, fp1;
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      mem[8'h00] = 16'hBEEF;

      repeat (3) @(negedge clk);
      chk("reset_outputs",
          {busy, req0_ack, req1_ack, err, ld_mar, ld_mdr, mio_en, r_w, gate_mdr_en, bus_drv_en},
          10'b0);
      chk("reset_rdata", rdata, 16'h0000);
      rst_n = 1'b1;

      access(0, 1'b0, 16'h3000, 16'h0000, 5, 1'b0);
      chk("rd_3000", rdata, 16'hBEEF);

      access(1, 1'b1, 16'h3002, 16'h1234, 6, 1'b0);
      chk("wr_keeps_rdata", rdata, 16'hBEEF);
      access(0, 1'b0, 16'h3002, 16'h0000, 5, 1'b0);
      chk("rd_3002", rdata, 16'h1234);

      access(1, 1'b1, 16'hFE06, 16'hA5A5, 6, 1'b0);
      chk("ddr", ddr, 16'hA5A5);

      // Contention: both valid continuously on both instances.
      @(posedge clk); #1;
      set_req(0, 1'b1, 1'b0, 16'h3000, 16'h0000);
      set_req(1, 1'b1, 1'b0, 16'h3002, 16'h0000);
      fp_v0 = 1'b1; fp_v1 = 1'b1;
      n = 0; cyc = 0; fp0 = 0; fp1 = 0;
      while (n < 4 && cyc < 80) begin
         @(negedge clk);
         cyc++;
         if (fp_ack0) fp0++;
         if (fp_ack1) fp1++;
         if (req0_ack) begin
            order[n] = 0; n++;
            chk("rr_rdata0", rdata, 16'hBEEF);
         end else if (req1_ack) begin
            order[n] = 1; n++;
            chk("rr_rdata1", rdata, 16'h1234);
         end
      end
      set_req(0, 1'b0, 1'b0, 16'h3000, 16'h0000);
      set_req(1, 1'b0, 1'b0, 16'h3002, 16'h0000);
      fp_v0 = 1'b0; fp_v1 = 1'b0;
      chk("rr_count", n, 4);
      chk("rr_order0", order[0], 0);
      chk("rr_order1", order[1], 1);
      chk("rr_order2", order[2], 0);
      chk("rr_order3", order[3], 1);
      chk("fp_req0_served", fp0 >= 3, 1'b1);
      chk("fp_req1_starved", fp1, 0);
      cyc = 0;
      while ((busy || fp_busy) && cyc < 30) begin
         @(negedge clk);
         cyc++;
      end
      chk("drain_idle", {busy, fp_busy}, 2'b00);

      // Device never ready: abort after the timeout window, rdata untouched.
      force_ready = 1'b0;
      access(0, 1'b1, 16'h3004, 16'h7777, 19, 1'b1);
      chk("timeout_rdata", rdata, 16'h1234);
      force_ready = 1'b1;
      access(1, 1'b0, 16'h3000, 16'h0000, 5, 1'b0);
      chk("after_timeout_rd", rdata, 16'hBEEF);

      // Asynchronous reset in the write-data phase.
      @(posedge clk); #1;
      set_req(1, 1'b1, 1'b1, 16'h3006, 16'h5555);
      repeat (3) @(negedge clk);
      chk("wdata_before_rst", {ld_mdr, bus_drv_en, bus_drv}, {2'b11, 16'h5555});
      #1 rst_n = 1'b0;
      #1;
      chk("async_rst_strobes",
          {busy, ld_mar, ld_mdr, mio_en, r_w, gate_mdr_en, bus_drv_en}, 7'b0);
      set_req(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
      n = 0;
      repeat (3) begin
         @(negedge clk);
         if (req0_ack || req1_ack) n++;
      end
      chk("no_ack_in_rst", n, 0);
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (req0_ack || req1_ack) n++;
      end
      chk("no_ack_after_rst", n, 0);
      chk("rst_clears_rdata", rdata, 16'h0000);
      chk("dropped_write", mem[8'h06], 16'h0000);
      access(0, 1'b0, 16'h3002, 16'h0000, 5, 1'b0);
      chk("post_rst_rd", rdata, 16'h1234);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
